// File: rtl/cache_pkg.sv
// Shared types and constants for the data-cache write buffer.
package cache_pkg;

    localparam int unsigned LINE_BITS   = 256;
    localparam int unsigned OFFSET_BITS = 5;
    localparam int unsigned TAG_BITS    = 32 - OFFSET_BITS;

    typedef struct packed {
        logic                 valid;
        logic [TAG_BITS-1:0]  tag;
        logic [LINE_BITS-1:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        D_IDLE,
        D_READ,
        D_WRITE
    } wb_dstate_t;

endpackage

// File: rtl/cache_write_buffer_if.sv
// Line-granular memory port: request (addr/read/write/wdata) and completion (rdata/resp).
interface cache_write_buffer_if;
    import cache_pkg::*;

    logic [31:0]          addr;
    logic                 read;
    logic                 write;
    logic [LINE_BITS-1:0] wdata;
    logic [LINE_BITS-1:0] rdata;
    logic                 resp;

    modport master (output addr, read, write, wdata, input rdata, resp);
    modport slave  (input addr, read, write, wdata, output rdata, resp);
endinterface

// File: rtl/wb_match.sv
// Combinational tag compare across all buffer entries, scanned oldest to youngest from head.
module wb_match
    import cache_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PW   = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]    i_valid,
    input  logic [TAG_BITS-1:0] i_tags [DEPTH],
    input  logic [TAG_BITS-1:0] i_tag,
    input  logic [PW-1:0]       i_head,
    input  logic                i_excl_head,
    output logic [DEPTH-1:0]    o_hit_vec,
    output logic [PW-1:0]       o_hit_off
);

    logic [PW-1:0] w_idx;

    // Later (younger) hits overwrite earlier ones, so the youngest match wins.
    always_comb begin
        o_hit_vec = '0;
        o_hit_off = '0;
        w_idx     = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            w_idx = i_head + PW'(k);
            if (i_valid[w_idx] && (i_tags[w_idx] == i_tag) && !(i_excl_head && (k == 0))) begin
                o_hit_vec[w_idx] = 1'b1;
                o_hit_off        = PW'(k);
            end
        end
    end

endmodule

// File: rtl/cache_write_buffer.sv
// Posted-write buffer: acknowledges evictions at once, drains them downstream in the background,
// serves reads from buffered lines and lets read misses overtake pending drains.
module cache_write_buffer
    import cache_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cache_write_buffer_if.slave  ufp,
    cache_write_buffer_if.master dfp
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    wb_entry_t            r_entries [DEPTH];
    logic [PW-1:0]        r_head, r_tail;
    logic [CW-1:0]        r_count;
    wb_dstate_t           r_dstate, w_dstate_d;
    logic                 r_resp;
    logic [LINE_BITS-1:0] r_rdata;
    logic                 r_dfp_read, r_dfp_write;
    logic [31:0]          r_dfp_addr;
    logic [LINE_BITS-1:0] r_dfp_wdata;

    logic [DEPTH-1:0]     w_valid, w_hit_vec;
    logic [TAG_BITS-1:0]  w_tags [DEPTH];
    logic [TAG_BITS-1:0]  w_tag;
    logic [PW-1:0]        w_hit_off, w_hit_idx;
    logic                 w_hit, w_busy, w_excl_head;
    logic                 w_coalesce, w_push, w_pop, w_rd_hit, w_rd_miss;
    logic                 w_read_start, w_drain_start;
    logic                 w_unused_addr;

    assign w_tag         = ufp.addr[31:OFFSET_BITS];
    assign w_unused_addr = ^ufp.addr[OFFSET_BITS-1:0];

    // Flatten entry state for the matcher.
    always_comb begin
        w_valid = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_valid[i] = r_entries[i].valid;
            w_tags[i]  = r_entries[i].tag;
        end
    end

    // A write must not coalesce into head while it drains or is about to start draining,
    // otherwise the data latched for the drain would be stale.
    assign w_excl_head = ufp.write &&
                         ((r_dstate == D_WRITE) || ((r_dstate == D_IDLE) && (r_count != '0)));

    wb_match #(
        .DEPTH (DEPTH)
    ) u_match (
        .i_valid     (w_valid),
        .i_tags      (w_tags),
        .i_tag       (w_tag),
        .i_head      (r_head),
        .i_excl_head (w_excl_head),
        .o_hit_vec   (w_hit_vec),
        .o_hit_off   (w_hit_off)
    );

    assign w_hit      = |w_hit_vec;
    assign w_hit_idx  = r_head + w_hit_off;
    assign w_busy     = r_resp || (r_dstate == D_READ);
    assign w_coalesce = !w_busy && ufp.write && w_hit;
    assign w_push     = !w_busy && ufp.write && !w_hit && (r_count < FULL);
    assign w_rd_hit   = !w_busy && ufp.read && w_hit;
    assign w_rd_miss  = !w_busy && ufp.read && !w_hit;
    assign w_pop      = (r_dstate == D_WRITE) && dfp.resp;

    // Downstream FSM next state; a pending read miss beats starting a drain.
    always_comb begin
        w_dstate_d    = r_dstate;
        w_read_start  = 1'b0;
        w_drain_start = 1'b0;
        unique case (r_dstate)
            D_IDLE: begin
                if (w_rd_miss) begin
                    w_dstate_d   = D_READ;
                    w_read_start = 1'b1;
                end else if (r_count != '0) begin
                    w_dstate_d    = D_WRITE;
                    w_drain_start = 1'b1;
                end
            end
            D_READ:  if (dfp.resp) w_dstate_d = D_IDLE;
            D_WRITE: if (dfp.resp) w_dstate_d = D_IDLE;
            default: w_dstate_d = D_IDLE;
        endcase
    end

    // Downstream FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_dstate <= D_IDLE;
        else        r_dstate <= w_dstate_d;
    end

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) r_entries[i] <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_pop) begin
                r_entries[r_head].valid <= 1'b0;
                r_head                  <= r_head + PW'(1);
            end
            if (w_push) begin
                r_entries[r_tail] <= '{valid: 1'b1, tag: w_tag, data: ufp.wdata};
                r_tail            <= r_tail + PW'(1);
            end
            if (w_coalesce) r_entries[w_hit_idx].data <= ufp.wdata;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Upstream completion for buffered writes and read hits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp  <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_resp <= w_coalesce || w_push || w_rd_hit;
            if (w_rd_hit) r_rdata <= r_entries[w_hit_idx].data;
        end
    end

    // Registered downstream request, held stable until the adapter responds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dfp_read  <= 1'b0;
            r_dfp_write <= 1'b0;
            r_dfp_addr  <= '0;
            r_dfp_wdata <= '0;
        end else if (w_read_start) begin
            r_dfp_read <= 1'b1;
            r_dfp_addr <= {w_tag, {OFFSET_BITS{1'b0}}};
        end else if (w_drain_start) begin
            r_dfp_write <= 1'b1;
            r_dfp_addr  <= {r_entries[r_head].tag, {OFFSET_BITS{1'b0}}};
            r_dfp_wdata <= r_entries[r_head].data;
        end else if (dfp.resp && (r_dstate != D_IDLE)) begin
            r_dfp_read  <= 1'b0;
            r_dfp_write <= 1'b0;
        end
    end

    assign dfp.read  = r_dfp_read;
    assign dfp.write = r_dfp_write;
    assign dfp.addr  = r_dfp_addr;
    assign dfp.wdata = r_dfp_wdata;

    // Read misses complete straight from the adapter.
    assign ufp.resp  = r_resp || ((r_dstate == D_READ) && dfp.resp);
    assign ufp.rdata = (r_dstate == D_READ) ? dfp.rdata : r_rdata;

endmodule

// File: tb/tb_cache_write_buffer.sv
// Scoreboard bench: requests push expected responses; a monitor pops them on ufp_resp.
// Reference model: a line-addressed memory view where a read returns the last write to that line.
module tb_cache_write_buffer;
    import cache_pkg::*;

    localparam int unsigned DEPTH = 2;

    typedef struct {
        bit         is_read;
        logic [255:0] data;
    } exp_t;

    typedef struct {
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] data;
    } dop_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cache_write_buffer_if u_ufp ();
    cache_write_buffer_if u_dfp ();

    cache_write_buffer #(
        .DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ufp   (u_ufp),
        .dfp   (u_dfp)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_uresp = 0;
    int n_dreads = 0;
    int dresp_mark = 0;
    bit hold = 1'b0;

    logic [255:0] golden [logic [26:0]];
    logic [255:0] mem    [logic [26:0]];
    exp_t sb [$];
    dop_t dlog [$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [255:0] dflt(input logic [26:0] t);
        return {8{5'b0, t}};
    endfunction

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] req);
        n_tests++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    // Adapter model: random latency, optional hold-off, one-cycle resp driven just after posedge.
    initial begin
        int lat;
        logic [26:0] t;
        dop_t d;
        u_dfp.resp  = 1'b0;
        u_dfp.rdata = '0;
        lat = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                u_dfp.resp = 1'b0;
                lat = 0;
                continue;
            end
            #1;
            if (u_dfp.resp) begin
                u_dfp.resp = 1'b0;
                lat = $urandom_range(0, 3);
            end else if ((u_dfp.read || u_dfp.write) && !hold) begin
                if (lat != 0) lat--;
                else begin
                    t = u_dfp.addr[31:5];
                    d.wr = u_dfp.write;
                    d.addr = u_dfp.addr;
                    d.data = u_dfp.wdata;
                    if (u_dfp.write) mem[t] = u_dfp.wdata;
                    else begin
                        u_dfp.rdata = mem.exists(t) ? mem[t] : dflt(t);
                        n_dreads++;
                    end
                    dlog.push_back(d);
                    if (dresp_mark < 0) dresp_mark = cyc;
                    u_dfp.resp = 1'b1;
                end
            end
        end
    end

    // Monitor: scoreboard pop on ufp_resp, plus downstream request-shape checks.
    initial begin
        exp_t e;
        bit prev_req;
        logic [31:0] prev_addr;
        logic [255:0] prev_wdata;
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_req = 1'b0;
                continue;
            end
            if (u_ufp.resp) begin
                n_uresp++;
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL resp_expected: got ufp_resp, required no response");
                end else begin
                    e = sb.pop_front();
                    if (e.is_read) check("read_data", u_ufp.rdata, e.data);
                end
            end
            if (u_dfp.read || u_dfp.write) begin
                check("dfp_shape", {u_dfp.addr[4:0], u_dfp.read & u_dfp.write}, '0);
                if (prev_req) begin
                    check("dfp_addr_stable", u_dfp.addr, prev_addr);
                    if (u_dfp.write) check("dfp_wdata_stable", u_dfp.wdata, prev_wdata);
                end
                prev_req = !u_dfp.resp;
                prev_addr = u_dfp.addr;
                prev_wdata = u_dfp.wdata;
            end else begin
                prev_req = 1'b0;
            end
        end
    end

    task automatic issue_req(input bit wr, input logic [31:0] addr, input logic [255:0] data,
                             output int t0);
        exp_t e;
        logic [26:0] t;
        t = addr[31:5];
        @(negedge clk);
        u_ufp.addr  = addr;
        u_ufp.wdata = wr ? data : rand_line();
        u_ufp.read  = !wr;
        u_ufp.write = wr;
        e.is_read = !wr;
        e.data = '0;
        if (wr) golden[t] = data;
        else e.data = golden.exists(t) ? golden[t] : dflt(t);
        sb.push_back(e);
        t0 = cyc;
    endtask

    task automatic wait_resp(output int rcyc);
        bit seen;
        exp_t junk;
        seen = 1'b0;
        rcyc = -1;
        for (int k = 0; k < 500 && !seen; k++) begin
            @(negedge clk);
            if (u_ufp.resp) begin
                seen = 1'b1;
                rcyc = cyc;
            end
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL req_timeout: got no ufp_resp, required one within 500 cycles");
            if (sb.size() > 0) junk = sb.pop_back();
        end
        u_ufp.read  = 1'b0;
        u_ufp.write = 1'b0;
    endtask

    task automatic do_req(input bit wr, input logic [31:0] addr, input logic [255:0] data,
                          output int lat);
        int t0, rc;
        issue_req(wr, addr, data, t0);
        wait_resp(rc);
        lat = rc - t0;
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 2000 && !done; k++) begin
            @(negedge clk);
            if (dut.r_count == '0 && !u_dfp.write && !u_dfp.read) done = 1'b1;
        end
        check("drain_done_count0", {255'b0, done}, 256'd1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ufp_resp"},  u_ufp.resp,  '0);
        check({tag, "_ufp_rdata"}, u_ufp.rdata, '0);
        check({tag, "_dfp_read"},  u_dfp.read,  '0);
        check({tag, "_dfp_write"}, u_dfp.write, '0);
        check({tag, "_dfp_addr"},  u_dfp.addr,  '0);
        check({tag, "_dfp_wdata"}, u_dfp.wdata, '0);
        check({tag, "_count"},     dut.r_count, '0);
    endtask

    initial begin
        int lat, t0, rc, base, dr0;
        logic [255:0] la, lb, lc, ld, le, lf, lg, lh;
        u_ufp.addr = '0;
        u_ufp.read = 1'b0;
        u_ufp.write = 1'b0;
        u_ufp.wdata = '0;
        la = rand_line(); lb = rand_line(); lc = rand_line(); ld = rand_line();
        le = rand_line(); lf = rand_line(); lg = rand_line(); lh = rand_line();

        // Reset state
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;

        // Single write, drained downstream
        dlog.delete();
        do_req(1'b1, 32'h0000_1040, la, lat);
        check("wr_latency", lat, 1);
        wait_drain();
        check("t1_dlog_size", dlog.size(), 1);
        if (dlog.size() >= 1) begin
            check("t1_dfp_addr", dlog[0].addr, 32'h0000_1040);
            check("t1_dfp_wdata", dlog[0].data, la);
        end

        // Read hit while the drain is held off
        hold = 1'b1;
        dr0 = n_dreads;
        do_req(1'b1, 32'h0000_0100, lb, lat);
        do_req(1'b0, 32'h0000_0100, '0, lat);
        check("rd_hit_latency", lat, 1);
        check("rd_hit_no_dfp_read", n_dreads, dr0);
        hold = 1'b0;
        wait_drain();

        // Full buffer stalls a third write until the first drain completes
        hold = 1'b1;
        do_req(1'b1, 32'h0000_0100, rand_line(), lat);
        do_req(1'b1, 32'h0000_0200, rand_line(), lat);
        base = n_uresp;
        issue_req(1'b1, 32'h0000_0300, rand_line(), t0);
        repeat (8) @(negedge clk);
        check("stall_no_resp", n_uresp - base, 0);
        dresp_mark = -1;
        hold = 1'b0;
        wait_resp(rc);
        check("stall_accept_cycle", rc, dresp_mark + 2);
        wait_drain();

        // Coalesce into a non-draining entry
        dlog.delete();
        hold = 1'b1;
        do_req(1'b1, 32'h0000_0100, lc, lat);
        do_req(1'b1, 32'h0000_0200, ld, lat);
        do_req(1'b1, 32'h0000_0200, le, lat);
        check("coalesce_count", dut.r_count, 2);
        hold = 1'b0;
        wait_drain();
        check("t4_dlog_size", dlog.size(), 2);
        if (dlog.size() >= 2) begin
            check("t4_op0", {dlog[0].wr, dlog[0].addr, dlog[0].data}, {1'b1, 32'h100, lc});
            check("t4_op1", {dlog[1].wr, dlog[1].addr, dlog[1].data}, {1'b1, 32'h200, le});
        end

        // Read miss overtakes a buffered line
        dlog.delete();
        hold = 1'b1;
        do_req(1'b1, 32'h0000_0100, lf, lat);
        do_req(1'b1, 32'h0000_0200, lg, lat);
        issue_req(1'b0, 32'h0000_0400, '0, t0);
        hold = 1'b0;
        wait_resp(rc);
        wait_drain();
        check("t5_dlog_size", dlog.size(), 3);
        if (dlog.size() >= 3) begin
            check("t5_op0", {dlog[0].wr, dlog[0].addr}, {1'b1, 32'h100});
            check("t5_op1", {dlog[1].wr, dlog[1].addr}, {1'b0, 32'h400});
            check("t5_op2", {dlog[2].wr, dlog[2].addr, dlog[2].data}, {1'b1, 32'h200, lg});
        end

        // Randomized traffic over a small line set
        for (int i = 0; i < 300; i++) begin
            do_req(1'($urandom_range(0, 1)),
                   {27'h100 + 27'($urandom_range(0, 5)), 5'($urandom_range(0, 31))},
                   rand_line(), lat);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_drain();
        foreach (golden[t]) check("mem_final", mem.exists(t) ? mem[t] : dflt(t), golden[t]);

        // Reset during a drain discards the buffered line
        hold = 1'b1;
        do_req(1'b1, 32'h0000_0500, lh, lat);
        @(negedge clk);
        check("pre_rst_dwrite", u_dfp.write, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check_outputs_zero("midrst");
        golden.delete();
        foreach (mem[t]) golden[t] = mem[t];
        sb.delete();
        hold = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dr0 = n_dreads;
        do_req(1'b0, 32'h0000_0500, '0, lat);
        check("post_rst_dfp_read", n_dreads, dr0 + 1);
        repeat (4) @(negedge clk);
        check("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
